// File: rtl/sba_ext_decoder.sv
// SBA external bus controller: decodes the master address, strobes one slave, returns data/ack/err.
// Optional busy watchdog enabled by defining SBA_DEC_TIMEOUT_EN.
module sba_ext_decoder #(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned SLAVE_AW = 12,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [15:0]              i_addr,
    input  logic                     i_stb,
    input  logic [3:0]               i_we,
    output logic                     o_ack,
    input  logic [31:0]              i_dat_w,
    output logic [31:0]              o_dat_r,
    output logic                     o_err,
    output logic [SLAVE_AW-1:0]      o_s_addr,
    output logic [N_SLAVES-1:0]      o_s_stb,
    output logic [3:0]               o_s_we,
    output logic [31:0]              o_s_dat_w,
    input  logic [N_SLAVES-1:0]      i_s_ack,
    input  logic [32*N_SLAVES-1:0]   i_s_dat_r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    if (N_SLAVES < 1 || N_SLAVES > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_cfg_check
        $error("sba_ext_decoder: N_SLAVES must be 1..4 and TIMEOUT 1..255");
    end

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           dat_r_q, dat_r_d;
    logic [SLAVE_AW-1:0]   s_addr_q, s_addr_d;
    logic [N_SLAVES-1:0]   s_stb_q, s_stb_d;
    logic [3:0]            s_we_q, s_we_d;
    logic [31:0]           s_dat_w_q, s_dat_w_d;

`ifdef SBA_DEC_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]            cnt_q, cnt_d;
`endif

    logic [1:0]            addr_idx;
    logic                  mapped;
    logic [N_SLAVES-1:0]   dec_stb;
    logic                  slave_ack;
    logic [31:0]           sel_dat;

    assign addr_idx = i_addr[SLAVE_AW+1:SLAVE_AW];
    assign mapped   = (i_addr[15:SLAVE_AW+2] == '0) && (32'(addr_idx) < N_SLAVES);

    // The strobe register is one-hot, so it doubles as the selector for ack and read data.
    always_comb begin
        dec_stb   = '0;
        sel_dat   = '0;
        slave_ack = |(i_s_ack & s_stb_q);
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            dec_stb[k] = (addr_idx == 2'(k));
            if (s_stb_q[k]) begin
                sel_dat = i_s_dat_r[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_r_d   = dat_r_q;
        s_addr_d  = s_addr_q;
        s_stb_d   = s_stb_q;
        s_we_d    = s_we_q;
        s_dat_w_d = s_dat_w_q;
`ifdef SBA_DEC_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_stb) begin
                    s_addr_d  = i_addr[SLAVE_AW-1:0];
                    s_we_d    = i_we;
                    s_dat_w_d = i_dat_w;
                    if (mapped) begin
                        s_stb_d = dec_stb;
                        state_d = BUSY;
`ifdef SBA_DEC_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        dat_r_d = '1;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                if (slave_ack) begin
                    s_stb_d = '0;
                    dat_r_d = sel_dat;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
`ifdef SBA_DEC_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    s_stb_d = '0;
                    dat_r_d = '1;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`else
                // Without the watchdog a silent slave keeps the controller in BUSY.
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                s_stb_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_r_q   <= '0;
            s_addr_q  <= '0;
            s_stb_q   <= '0;
            s_we_q    <= '0;
            s_dat_w_q <= '0;
`ifdef SBA_DEC_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_r_q   <= dat_r_d;
            s_addr_q  <= s_addr_d;
            s_stb_q   <= s_stb_d;
            s_we_q    <= s_we_d;
            s_dat_w_q <= s_dat_w_d;
`ifdef SBA_DEC_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign o_ack     = ack_q;
    assign o_err     = err_q;
    assign o_dat_r   = dat_r_q;
    assign o_s_addr  = s_addr_q;
    assign o_s_stb   = s_stb_q;
    assign o_s_we    = s_we_q;
    assign o_s_dat_w = s_dat_w_q;

endmodule

// File: tb/tb_sba_ext_decoder.sv
// Scoreboard bench for sba_ext_decoder: master + slave models driven at negedge, outputs sampled at negedge.
module tb_sba_ext_decoder;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned TO = 8;

    typedef struct {
        logic        err;
        logic [31:0] dat;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       addr;
    logic              stb;
    logic [3:0]        we;
    logic              ack;
    logic [31:0]       dat_w;
    logic [31:0]       dat_r;
    logic              err;
    logic [AW-1:0]     s_addr;
    logic [NS-1:0]     s_stb;
    logic [3:0]        s_we;
    logic [31:0]       s_dat_w;
    logic [NS-1:0]     s_ack;
    logic [32*NS-1:0]  s_dat_r;

    int          vectors     = 0;
    int          miscompares = 0;
    resp_t       sb[$];
    logic [31:0] last_dat    = '0;

    always #5 clk = ~clk;

    sba_ext_decoder #(
        .N_SLAVES (NS),
        .SLAVE_AW (AW),
        .TIMEOUT  (TO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_addr    (addr),
        .i_stb     (stb),
        .i_we      (we),
        .o_ack     (ack),
        .i_dat_w   (dat_w),
        .o_dat_r   (dat_r),
        .o_err     (err),
        .o_s_addr  (s_addr),
        .o_s_stb   (s_stb),
        .o_s_we    (s_we),
        .o_s_dat_w (s_dat_w),
        .i_s_ack   (s_ack),
        .i_s_dat_r (s_dat_r)
    );

    // One master transaction; wait_n < 0 means the addressed slave never acks.
    task automatic run_txn(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d,
                           input int wait_n, input logic [3:0] spur);
        logic [1:0]  idx;
        logic        mapped;
        logic [3:0]  oh;
        logic [3:0]  exp_stb;
        logic [31:0] rdata;
        int          lat;
        bit          done;
        resp_t       exp_r;
        resp_t       got_r;
        idx    = a[13:12];
        mapped = (a[15:14] == 2'b00);
        oh     = 4'b0001 << idx;
        rdata  = s_dat_r[32*int'(idx) +: 32];
        lat    = !mapped ? 1 : (wait_n < 0 ? int'(TO) + 1 : wait_n + 2);
        exp_r.err = !mapped || (wait_n < 0);
        exp_r.dat = exp_r.err ? 32'hFFFF_FFFF : rdata;
        sb.push_back(exp_r);
        addr  = a;
        we    = w;
        dat_w = d;
        stb   = 1'b1;
        done  = 1'b0;
        for (int cyc = 1; cyc <= lat && !done; cyc++) begin
            @(negedge clk);
            exp_stb = (mapped && cyc < lat) ? oh : 4'b0000;
            vectors++;
            if (s_stb !== exp_stb) begin
                miscompares++;
                $display("FAIL s_stb addr=%h cyc=%0d got=%b exp=%b", a, cyc, s_stb, exp_stb);
            end
            if (cyc == 1) begin
                vectors += 3;
                if (s_addr !== a[11:0]) begin
                    miscompares++;
                    $display("FAIL s_addr got=%h exp=%h", s_addr, a[11:0]);
                end
                if (s_we !== w) begin
                    miscompares++;
                    $display("FAIL s_we got=%h exp=%h", s_we, w);
                end
                if (s_dat_w !== d) begin
                    miscompares++;
                    $display("FAIL s_dat_w got=%h exp=%h", s_dat_w, d);
                end
            end
            if (cyc < lat) begin
                vectors += 2;
                if (ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL early_ack addr=%h cyc=%0d got=%b exp=0", a, cyc, ack);
                end
                if (dat_r !== last_dat) begin
                    miscompares++;
                    $display("FAIL dat_r_hold cyc=%0d got=%h exp=%h", cyc, dat_r, last_dat);
                end
            end else begin
                done = 1'b1;
                vectors++;
                if (ack !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ack_latency addr=%h cyc=%0d got=%b exp=1", a, cyc, ack);
                end
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_empty got=0 entries exp=1");
                end else begin
                    got_r = sb.pop_front();
                    vectors += 2;
                    if (dat_r !== got_r.dat) begin
                        miscompares++;
                        $display("FAIL dat_r addr=%h got=%h exp=%h", a, dat_r, got_r.dat);
                    end
                    if (err !== got_r.err) begin
                        miscompares++;
                        $display("FAIL err addr=%h got=%b exp=%b", a, err, got_r.err);
                    end
                    last_dat = got_r.dat;
                end
            end
            s_ack = done ? 4'b0000 : (spur & ~oh);
            if (!done && mapped && wait_n >= 0 && cyc == wait_n + 1) s_ack = s_ack | oh;
        end
        stb   = 1'b0;
        s_ack = '0;
        @(negedge clk);
        vectors += 3;
        if (ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_single_cycle got=%b exp=0", ack);
        end
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_after_done got=%b exp=0", err);
        end
        if (s_stb !== 4'b0000) begin
            miscompares++;
            $display("FAIL s_stb_idle got=%b exp=0000", s_stb);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        stb   = 1'b1;
        addr  = 16'h0000;
        we    = 4'h0;
        dat_w = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                rst = 1'b0;
                stb = 1'b0;
            end
            @(negedge clk);
            vectors += 4;
            if (s_stb !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_s_stb i=%0d got=%b exp=0000", i, s_stb);
            end
            if (ack !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ack i=%0d got=%b exp=0", i, ack);
            end
            if (dat_r !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_dat_r i=%0d got=%h exp=0", i, dat_r);
            end
            if (err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_err i=%0d got=%b exp=0", i, err);
            end
        end
        last_dat = '0;
    endtask

    task automatic test_write();
        run_txn(16'h0000, 4'h1, 32'h0000_00A5, 0, 4'b0000);
    endtask

    task automatic test_read_wait();
        run_txn(16'h2010, 4'h0, 32'h0, 3, 4'b0000);
    endtask

    task automatic test_unmapped();
        run_txn(16'h8000, 4'h0, 32'h0, 0, 4'b0000);
        run_txn(16'h4FFF, 4'hF, 32'h5555_AAAA, 0, 4'b1111);
    endtask

    task automatic test_spurious_ack();
        run_txn(16'h0004, 4'h0, 32'h0, 2, 4'b1000);
        run_txn(16'h3FFC, 4'h0, 32'h0, 1, 4'b0111);
    endtask

`ifdef SBA_DEC_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(16'h1000, 4'h0, 32'h0, -1, 4'b0000);
        run_txn(16'h1008, 4'h0, 32'h0, int'(TO) - 1, 4'b0000);
    endtask
`endif

    task automatic test_reset_mid();
        addr  = 16'h0000;
        we    = 4'h0;
        stb   = 1'b1;
        s_ack = 4'b1000;
        for (int cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clk);
            vectors++;
            if (s_stb !== 4'b0001) begin
                miscompares++;
                $display("FAIL mid_busy_s_stb cyc=%0d got=%b exp=0001", cyc, s_stb);
            end
        end
        rst   = 1'b1;
        stb   = 1'b0;
        s_ack = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            vectors += 3;
            if (s_stb !== 4'b0000) begin
                miscompares++;
                $display("FAIL mid_reset_s_stb cyc=%0d got=%b exp=0000", cyc, s_stb);
            end
            if (ack !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_reset_ack cyc=%0d got=%b exp=0", cyc, ack);
            end
            if (dat_r !== 32'h0) begin
                miscompares++;
                $display("FAIL mid_reset_dat_r cyc=%0d got=%h exp=0", cyc, dat_r);
            end
        end
        last_dat = '0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs[6] = '{16'h3000, 16'h1ABC, 16'hC000, 16'h0FFF, 16'h2000, 16'h1000};
        int          waits[6] = '{0, 1, 0, 4, 0, 2};
        for (int i = 0; i < 6; i++) begin
            run_txn(addrs[i], 4'(i), 32'hA000_0000 + 32'(i), waits[i], 4'b0000);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        s_ack   = '0;
        s_dat_r = {32'hDEAD_0003, 32'h1234_5678, 32'hCAFE_0001, 32'h0BAD_F00D};
        test_reset();
        test_write();
        test_read_wait();
        test_unmapped();
        test_spurious_ack();
`ifdef SBA_DEC_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not complete");
    end

endmodule
